// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
    localparam int          CNT_W          = 4;

endpackage

// File: rtl/dmem_word_array.sv
// Single-port MEMORY_DEPTH x 32 RAM with write enable and registered read.
module dmem_word_array #(
    parameter int MEMORY_DEPTH = 256,
    parameter int IDX_W        = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [MEMORY_DEPTH];
    logic [31:0] r_rdata;

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_dmem_responder.sv
// MEM-stage data-memory responder with configurable wait states and core stall.
// Define DMEM_ADDR_CHECK_EN to flag misaligned / out-of-range accesses.
module mips_dmem_responder
    import dmem_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 256,
    parameter int          LATENCY      = 2,
    parameter logic [31:0] BASE_ADDR    = DMEM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic        ready_o,
    output logic [31:0] read_data_o,
    output logic        error_o,
    output logic        busy_o,
    output logic        stall_o
);

    localparam int          IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [31:0] SPAN  = 32'(4 * MEMORY_DEPTH);

    dmem_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_ready;
    logic             r_err;
    logic             r_busy;
    logic             r_rd_zero;

    logic             w_we_cur;
    logic [31:0]      w_addr_cur;
    logic [31:0]      w_wdata_cur;
    logic [31:0]      w_off;
    logic [29:0]      w_word;
    logic [IDX_W-1:0] w_idx;
    logic             w_bad;
    logic             w_commit;
    logic             w_ram_we;
    logic             w_ram_re;
    logic [31:0]      w_ram_rdata;

    // With zero latency the commit happens in IDLE, before anything is captured.
    assign w_we_cur    = (r_state == S_IDLE) ? we_i         : r_we;
    assign w_addr_cur  = (r_state == S_IDLE) ? address_i    : r_addr;
    assign w_wdata_cur = (r_state == S_IDLE) ? write_data_i : r_wdata;

    assign w_off  = w_addr_cur - BASE_ADDR;
    assign w_word = 30'(w_off >> 2);
    assign w_idx  = IDX_W'(w_word % 30'(MEMORY_DEPTH));

`ifdef DMEM_ADDR_CHECK_EN
    assign w_bad = (w_addr_cur[1:0] != 2'b00) || (w_off >= SPAN);
`else
    assign w_bad = 1'b0;
`endif

    assign w_commit = ((r_state == S_IDLE) && req_i && (LATENCY == 0)) ||
                      ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));
    assign w_ram_we = w_commit &  w_we_cur & ~w_bad;
    assign w_ram_re = w_commit & ~w_we_cur & ~w_bad;

    dmem_word_array #(
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .IDX_W        (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_idx),
        .i_wdata (w_wdata_cur),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_rd_zero <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_addr  <= address_i;
                        r_wdata <= write_data_i;
                        r_busy  <= 1'b1;
                        if (LATENCY == 0) begin
                            r_state <= S_RESP;
                            r_cnt   <= '0;
                            r_ready <= 1'b1;
                            r_err   <= w_bad;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_W'(LATENCY);
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_err   <= w_bad;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // A faulted load masks the RAM output to zero until the next good load.
            if (w_commit && !w_we_cur) begin
                r_rd_zero <= w_bad;
            end
        end
    end

    assign ready_o     = r_ready;
    assign error_o     = r_err;
    assign busy_o      = r_busy;
    assign read_data_o = r_rd_zero ? 32'h0 : w_ram_rdata;
    assign stall_o     = req_i & ~r_ready;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench: instance A uses LATENCY=2, instance B uses LATENCY=0.
module tb_mips_dmem_responder;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
        bit          chk_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [31:0] addr_a = 32'h0, wd_a = 32'h0, addr_b = 32'h0, wd_b = 32'h0;
    logic        ready_a, err_a, busy_a, stall_a;
    logic        ready_b, err_b, busy_b, stall_b;
    logic [31:0] rd_a, rd_b;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q_a[$];
    exp_t q_b[$];

`ifdef DMEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_dmem_responder #(.MEMORY_DEPTH(256), .LATENCY(2), .BASE_ADDR(32'h1001_0000)) dut_a (
        .clk(clk), .reset(reset), .req_i(req_a), .we_i(we_a), .address_i(addr_a),
        .write_data_i(wd_a), .ready_o(ready_a), .read_data_o(rd_a), .error_o(err_a),
        .busy_o(busy_a), .stall_o(stall_a));

    mips_dmem_responder #(.MEMORY_DEPTH(256), .LATENCY(0), .BASE_ADDR(32'h1001_0000)) dut_b (
        .clk(clk), .reset(reset), .req_i(req_b), .we_i(we_b), .address_i(addr_b),
        .write_data_i(wd_b), .ready_o(ready_b), .read_data_o(rd_b), .error_o(err_b),
        .busy_o(busy_b), .stall_o(stall_b));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: every response strobe is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ready_a) begin
            if (q_a.size() == 0) begin
                n_total++;
                $display("FAIL a_unexpected_ready: ready_o=1 with nothing outstanding (cyc %0d)", cyc);
            end else begin
                e = q_a.pop_front();
                chk("a_ready_cycle", 64'(cyc), 64'(e.cyc));
                chk("a_error", 64'(err_a), 64'(e.err));
                if (e.chk_rd) chk("a_read_data", 64'(rd_a), 64'(e.rd));
            end
        end
        if (ready_b) begin
            if (q_b.size() == 0) begin
                n_total++;
                $display("FAIL b_unexpected_ready: ready_o=1 with nothing outstanding (cyc %0d)", cyc);
            end else begin
                e = q_b.pop_front();
                chk("b_ready_cycle", 64'(cyc), 64'(e.cyc));
                chk("b_error", 64'(err_b), 64'(e.err));
                if (e.chk_rd) chk("b_read_data", 64'(rd_b), 64'(e.rd));
            end
        end
    end

    // One transaction; scrambles the inputs during WAIT to prove they are captured.
    task automatic xact(input bit b, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit exp_err, input bit chk_rd);
        int   lat = b ? 0 : 2;
        exp_t e;
        @(negedge clk);
        e.cyc = cyc + lat + 1; e.rd = exp_rd; e.err = exp_err; e.chk_rd = chk_rd;
        if (b) begin req_b = 1'b1; we_b = we; addr_b = a; wd_b = d; q_b.push_back(e); end
        else   begin req_a = 1'b1; we_a = we; addr_a = a; wd_a = d; q_a.push_back(e); end
        for (int k = 0; k <= lat; k++) begin
            #1;
            chk(b ? "b_stall_hold" : "a_stall_hold", 64'(b ? stall_b : stall_a), 64'd1);
            chk(b ? "b_busy_hold" : "a_busy_hold", 64'(b ? busy_b : busy_a), 64'(k != 0));
            if (!b && k == 1) begin addr_a = addr_a ^ 32'h0000_00F0; wd_a = ~wd_a; we_a = ~we_a; end
            @(negedge clk);
        end
        #1;
        chk(b ? "b_stall_resp" : "a_stall_resp", 64'(b ? stall_b : stall_a), 64'd0);
        chk(b ? "b_busy_resp" : "a_busy_resp", 64'(b ? busy_b : busy_a), 64'd1);
        if (b) req_b = 1'b0; else req_a = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   t0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("a_idle_outputs", {27'd0, ready_a, err_a, busy_a, stall_a, rd_a}, 64'd0);
        end
        chk("b_idle_outputs", {27'd0, ready_b, err_b, busy_b, stall_b, rd_b}, 64'd0);

        xact(0, 1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 0, 0);
        xact(0, 0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 0, 1);
        xact(0, 1, 32'h1001_0000, 32'h1111_2222, 32'h0, 0, 0);
        xact(0, 1, 32'h1001_0004, 32'h3333_4444, 32'h0, 0, 0);
        xact(0, 1, 32'h1001_0010, 32'h0BAD_F00D, 32'h0, 0, 0);
        // Misaligned load: zero + error when checked, word 1 when low bits are ignored.
        xact(0, 0, 32'h1001_0006, 32'h0, CHK ? 32'h0 : 32'h3333_4444, CHK, 1);
        // Out-of-range store: suppressed when checked, wraps onto word 0 otherwise.
        xact(0, 1, 32'h1001_0400, 32'hA5A5_A5A5, 32'h0, CHK, 0);
        xact(0, 0, 32'h1001_0000, 32'h0, CHK ? 32'h1111_2222 : 32'hA5A5_A5A5, 0, 1);

        // Reset during WAIT of a store aborts it.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h1001_0010; wd_a = 32'h1234_5678;
        @(negedge clk);
        reset = 1'b1; req_a = 1'b0;
        #1;
        chk("a_reset_ctrl", {60'd0, ready_a, err_a, busy_a, stall_a}, 64'd0);
        chk("a_reset_rdata", 64'(rd_a), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        xact(0, 0, 32'h1001_0010, 32'h0, 32'h0BAD_F00D, 0, 1);

        // Zero-latency instance, back-to-back loads with req held high.
        xact(1, 1, 32'h1001_0000, 32'h5555_6666, 32'h0, 0, 0);
        xact(1, 1, 32'h1001_0004, 32'h7777_8888, 32'h0, 0, 0);
        @(negedge clk);
        t0 = cyc;
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'h1001_0000;
        e.cyc = t0 + 1; e.rd = 32'h5555_6666; e.err = 1'b0; e.chk_rd = 1'b1;
        q_b.push_back(e);
        #1 chk("b2b_stall_c0", 64'(stall_b), 64'd1);
        @(negedge clk);
        #1 chk("b2b_stall_c1", 64'(stall_b), 64'd0);
        addr_b = 32'h1001_0004;
        e.cyc = t0 + 3; e.rd = 32'h7777_8888;
        q_b.push_back(e);
        @(negedge clk);
        #1 chk("b2b_gap_busy", 64'(busy_b), 64'd0);
        chk("b2b_gap_stall", 64'(stall_b), 64'd1);
        @(negedge clk);
        #1 chk("b2b_stall_c3", 64'(stall_b), 64'd0);
        req_b = 1'b0;

        repeat (4) @(negedge clk);
        chk("a_queue_drained", 64'(q_a.size()), 64'd0);
        chk("b_queue_drained", 64'(q_b.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_dmem_responder.md
# mips_dmem_responder

Multi-cycle data-memory responder that answers the MEM stage of the pipelined MIPS core. It accepts one load/store request at a time over a req/ready handshake and inserts a configurable number of wait cycles. It raises a combinational stall so the core freezes its pipeline registers until the access completes. It replaces the single-cycle RAM at the data port and is the responder end of the core's load/store interface.

## Interface
- MEMORY_DEPTH, 256, number of 32-bit words in the array
- LATENCY, 2, wait cycles between accept and response (0 to 15)
- BASE_ADDR, 32'h1001_0000, byte address of word 0
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_i  input  1  request valid; held high by the core until ready_o
- we_i  input  1  1 = store (sw), 0 = load (lw)
- address_i  input  32  byte address (ALU result)
- write_data_i  input  32  store data
- ready_o  output  1  one-cycle response strobe
- read_data_o  output  32  load data; valid while ready_o = 1
- error_o  output  1  response carries an address error; valid with ready_o
- busy_o  output  1  transaction in flight (WAIT or RESP)
- stall_o  output  1  req_i & ~ready_o, combinational; gates every pipeline register and the PC

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req_i = 1, capture we_i, address_i and write_data_i. Go to WAIT with the counter loaded to LATENCY. If LATENCY = 0, go straight to RESP.
- WAIT: decrement the counter. When it reaches 1, go to RESP on the next edge. Inputs changing during WAIT are ignored because the captured copies are used.
- Commit edge is the WAIT→RESP (or IDLE→RESP) edge:
  - A store writes the captured data to word (addr − BASE_ADDR) >> 2.
  - A load registers that word into read_data_o.
- RESP: ready_o = 1 for exactly one cycle, then the FSM always returns to IDLE. req_i is not sampled in RESP, so there is a minimum one-cycle gap between transactions.
- Loads return 32'h0 on error. Stores flagged as errors do not modify the array.
- read_data_o holds its last value outside RESP.
- Arithmetic:
  - The offset subtraction is 32-bit unsigned.
  - The index uses offset[31:2].
  - In range means offset < 4*MEMORY_DEPTH.
  - Aligned means address[1:0] = 0.
- Reset values: state IDLE; ready_o 0, error_o 0, busy_o 0, read_data_o 32'h0, counter 0.
- Array contents are not cleared by reset.
- Reset mid-transaction aborts it. If reset lands before the commit edge, no write occurs and no ready_o is issued.

## Timing
- Request seen high in cycle 0 (IDLE) → ready_o high in cycle LATENCY+1.
- stall_o is high in cycles 0 through LATENCY and low in cycle LATENCY+1, so the core advances on the edge that ends the RESP cycle.
- busy_o is high in cycles 1 through LATENCY+1.
- With LATENCY = 0, ready_o is high in cycle 1 and the stall lasts one cycle.
- Back-to-back requests: the next accept happens at the earliest in cycle LATENCY+2.

## Configuration
- DMEM_ADDR_CHECK_EN defined:
  - Misaligned or out-of-range accesses set error_o with ready_o.
  - Stores are suppressed and loads return 0.
- DMEM_ADDR_CHECK_EN undefined:
  - error_o is tied to 0.
  - The index is offset[31:2] modulo MEMORY_DEPTH (wrap-around).
  - address[1:0] is ignored.
  - All accesses complete normally.

## Structure
- Package dmem_pkg holds:
  - the FSM state encoding (IDLE, WAIT, RESP);
  - the default BASE_ADDR constant;
  - the counter width constant (4 bits).
- Sub-module dmem_word_array: synchronous single-port RAM of MEMORY_DEPTH × 32 bits with a write enable and a registered read. It is instantiated once. FSM, capture registers and address checking stay in the top.

## Test plan
- Reset then idle, no req: all outputs 0, stall_o 0, state IDLE for 10 cycles.
- Store then load, LATENCY = 2: sw 32'hDEAD_BEEF to 32'h1001_0008 → ready_o in cycle 3, stall_o high cycles 0–2. Then lw from 32'h1001_0008 → read_data_o = 32'hDEAD_BEEF with ready_o, error_o 0.
- LATENCY = 0 back-to-back: two loads with req_i held continuously → ready_o in cycles 1 and 3, IDLE gap in cycle 2.
- Address errors with the macro on:
  - lw 32'h1001_0006 → error_o 1, read_data_o 0.
  - sw 32'h1001_0400 (depth 256) → error_o 1, word 0 unchanged.
- Address errors with the macro off: sw 32'hA5A5_A5A5 to 32'h1001_0400 → word 0 reads 32'hA5A5_A5A5, error_o 0.
- Reset asserted in WAIT of a sw of 32'h1234_5678 to 32'h1001_0010 → no ready_o, outputs 0. A later lw of that address returns the prior content.
